z88_memarb: RTL



---
 rtl/z88_memarb.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/z88_memarb.sv
// z88_memarb: single-port SRAM arbiter/sequencer for Z88 slot 0.
// The lower half of the SRAM holds the ROM image and the upper half the RAM.
// The Blink-decoded CPU bus and a loader/debug port share the SRAM.
// Optional feature macro: ROM_WP_EN. When it is defined, CPU writes to the
// ROM half are swallowed in one cycle without touching the SRAM.
//
// Loader handshake: ldr_req is a held request. ldr_we, ldr_a and ldr_di must
// stay stable while ldr_req is high. Each transfer completes with a one-cycle
// ldr_ack. ldr_do is valid in that cycle and holds until the next loader read.
// If ldr_req is still high in the ack cycle, that is taken as the next request.
module z88_memarb #(
    parameter int ADDR_W  = 20,
    parameter int ACC_CYC = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-2:0] cpu_a,
    input  logic              cpu_ipce_n,
    input  logic              cpu_irce_n,
    input  logic              cpu_roe_n,
    input  logic              cpu_wrb_n,
    input  logic [7:0]        cpu_di,
    output logic [7:0]        cpu_do,
    output logic              cpu_wait_n,
    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [ADDR_W-1:0] ldr_a,
    input  logic [7:0]        ldr_di,
    output logic              ldr_ack,
    output logic [7:0]        ldr_do,
    output logic [ADDR_W-1:0] sram_a,
    output logic [7:0]        sram_di,
    input  logic [7:0]        sram_do,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n
);

    localparam logic [2:0] LAST_CYC = 3'(ACC_CYC);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CPU_RD = 3'd1,
        S_CPU_WR = 3'd2,
        S_LDR_RD = 3'd3,
        S_LDR_WR = 3'd4
    } state_t;

    state_t            state;
    logic [2:0]        cnt;        // cycle index inside an access, 1..ACC_CYC
    logic              served;     // current CPU strobe already got its access
    logic              last_cpu;   // last completed access belonged to the CPU

    logic              ce_any;
    logic              stb_any;
    logic              cpu_bus_idle;
    logic              cpu_req;
    logic              cpu_wr;
    logic              grant_cpu;
    logic              last_cyc;
    logic              cpu_done;
    logic              rom_wp_hit;
    logic [ADDR_W-1:0] cpu_addr;

    assign ce_any       = ~cpu_ipce_n | ~cpu_irce_n;
    assign stb_any      = ~cpu_roe_n | ~cpu_wrb_n;
    // Both enables high or both strobes high ends the CPU cycle.
    assign cpu_bus_idle = (cpu_ipce_n & cpu_irce_n) | (cpu_roe_n & cpu_wrb_n);
    assign cpu_req      = ce_any & stb_any & ~served;
    // Write wins when both strobes are low.
    assign cpu_wr       = ~cpu_wrb_n;
    // ROM enable wins when both enables are low: the top address bit is 0.
    assign cpu_addr     = {cpu_ipce_n, cpu_a};

    // The CPU takes the slot unless it had the last one and the loader waits.
    assign grant_cpu    = (state == S_IDLE) & cpu_req & ~(last_cpu & ldr_req);
    assign last_cyc     = (cnt == LAST_CYC);

`ifdef ROM_WP_EN
    assign rom_wp_hit   = grant_cpu & cpu_wr & ~cpu_ipce_n;
`else
    assign rom_wp_hit   = 1'b0;
`endif

    assign cpu_done     = (((state == S_CPU_RD) | (state == S_CPU_WR)) & last_cyc) | rom_wp_hit;

    // The CPU is held while its request is present and not yet completed.
    assign cpu_wait_n   = ~cpu_req;

    // Track whether the current CPU strobe has already been serviced.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            served <= 1'b0;
        end else if (cpu_bus_idle) begin
            served <= 1'b0;
        end else if (cpu_done) begin
            served <= 1'b1;
        end
    end

    // Access sequencer: arbitrate in IDLE, then run a fixed-length SRAM cycle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            cnt       <= 3'd0;
            last_cpu  <= 1'b0;
            sram_ce_n <= 1'b1;
            sram_oe_n <= 1'b1;
            sram_we_n <= 1'b1;
            sram_a    <= '0;
            sram_di   <= 8'h00;
            cpu_do    <= 8'hFF;
            ldr_do    <= 8'h00;
            ldr_ack   <= 1'b0;
        end else begin
            ldr_ack <= 1'b0;
            case (state)
                S_IDLE: begin
                    cnt <= 3'd1;
                    if (rom_wp_hit) begin
                        // Protected ROM write: complete at once, no SRAM cycle.
                        last_cpu <= 1'b1;
                    end else if (grant_cpu) begin
                        sram_a    <= cpu_addr;
                        sram_ce_n <= 1'b0;
                        sram_we_n <= 1'b1;
                        if (cpu_wr) begin
                            state     <= S_CPU_WR;
                            sram_di   <= cpu_di;
                            sram_oe_n <= 1'b1;
                        end else begin
                            state     <= S_CPU_RD;
                            sram_oe_n <= 1'b0;
                        end
                    end else if (ldr_req) begin
                        sram_a    <= ldr_a;
                        sram_ce_n <= 1'b0;
                        sram_we_n <= 1'b1;
                        if (ldr_we) begin
                            state     <= S_LDR_WR;
                            sram_di   <= ldr_di;
                            sram_oe_n <= 1'b1;
                        end else begin
                            state     <= S_LDR_RD;
                            sram_oe_n <= 1'b0;
                        end
                    end
                end
                S_CPU_RD, S_CPU_WR, S_LDR_RD, S_LDR_WR: begin
                    if (last_cyc) begin
                        state     <= S_IDLE;
                        sram_ce_n <= 1'b1;
                        sram_oe_n <= 1'b1;
                        sram_we_n <= 1'b1;
                        if (state == S_CPU_RD) begin
                            cpu_do <= sram_do;
                        end
                        if (state == S_LDR_RD) begin
                            ldr_do <= sram_do;
                        end
                        last_cpu <= (state == S_CPU_RD) | (state == S_CPU_WR);
                        ldr_ack  <= (state == S_LDR_RD) | (state == S_LDR_WR);
                    end else begin
                        cnt <= cnt + 3'd1;
                        // First write cycle is address/data setup, then we_n low.
                        if ((state == S_CPU_WR) || (state == S_LDR_WR)) begin
                            sram_we_n <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
